pad_cfg_ctrl: RTL and testbench



---
 rtl/pad_cfg_pkg.sv | 81 ++++++++
 rtl/pad_cfg_regs.sv | 78 +++++++
 rtl/pad_cfg_ctrl.sv | 116 +++++++++++
 tb/tb_pad_cfg_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cfg_pkg.sv
// Shared state codes, tech_cfg bit offsets, register map and per-pad field type for the
// GPIO ring configuration sequencer.
package pad_cfg_pkg;

    typedef logic [2:0] pad_state_t;

    localparam pad_state_t StOff   = 3'd0;
    localparam pad_state_t StPwr   = 3'd1;
    localparam pad_state_t StEnh   = 3'd2;
    localparam pad_state_t StCfg   = 3'd3;
    localparam pad_state_t StRel   = 3'd4;
    localparam pad_state_t StReady = 3'd5;
    localparam pad_state_t StHold  = 3'd6;
    localparam pad_state_t StUpd   = 3'd7;

    localparam int unsigned BitHldHN          = 0;
    localparam int unsigned BitEnableH        = 1;
    localparam int unsigned BitEnableInpH     = 2;
    localparam int unsigned BitEnableVddaH    = 3;
    localparam int unsigned BitEnableVswitchH = 4;
    localparam int unsigned BitEnableVddio    = 5;
    localparam int unsigned BitIbModeSel      = 6;
    localparam int unsigned BitVtripSel       = 7;
    localparam int unsigned BitSlow           = 8;
    localparam int unsigned BitDm             = 13;

    localparam logic [5:0] PAD_LAST = 6'd35;
    localparam logic [5:0] CTRL     = 6'd36;
    localparam logic [5:0] STATUS   = 6'd37;

    typedef struct packed {
        logic       ib_mode_sel;
        logic       vtrip_sel;
        logic       slow;
        logic [2:0] dm;
    } pad_field_t;

    localparam pad_field_t ShadowRst = '{ib_mode_sel: 1'b0, vtrip_sel: 1'b0, slow: 1'b0,
                                         dm: 3'b110};

    // Successor of each timed state; READY and the commit path are handled by the caller.
    function automatic pad_state_t seq_next(pad_state_t st);
        pad_state_t nxt;
        case (st)
            StOff:   nxt = StPwr;
            StPwr:   nxt = StEnh;
            StEnh:   nxt = StCfg;
            StCfg:   nxt = StRel;
            StRel:   nxt = StReady;
            StHold:  nxt = StUpd;
            StUpd:   nxt = StRel;
            default: nxt = StReady;
        endcase
        return nxt;
    endfunction

    // Control bits accumulate along the sequence; hold is released only in REL and READY.
    function automatic logic [15:0] pad_cfg_word(pad_state_t st, pad_field_t f);
        logic [15:0] w;
        w = '0;
        if (st != StOff) begin
            w[BitEnableVddaH]    = 1'b1;
            w[BitEnableVswitchH] = 1'b1;
            w[BitEnableVddio]    = 1'b1;
        end
        if (!(st inside {StOff, StPwr})) begin
            w[BitEnableH] = 1'b1;
        end
        if (!(st inside {StOff, StPwr, StEnh})) begin
            w[BitDm +: 3]    = f.dm;
            w[BitSlow]       = f.slow;
            w[BitVtripSel]   = f.vtrip_sel;
            w[BitIbModeSel]  = f.ib_mode_sel;
        end
        if (st inside {StRel, StReady}) begin
            w[BitHldHN] = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pad_cfg_regs.sv
// Register front end: per-pad shadow array, address decode, one-cycle response pipeline
// and the commit_pending flag.
module pad_cfg_regs
    import pad_cfg_pkg::*;
#(
    parameter int unsigned NumPads = 36
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     reg_req_i,
    input  logic                     reg_we_i,
    input  logic [5:0]               reg_addr_i,
    input  logic [31:0]              reg_wdata_i,
    output logic                     reg_gnt_o,
    output logic                     reg_rvalid_o,
    output logic [31:0]              reg_rdata_o,
    input  logic [2:0]               state_i,
    input  logic                     commit_clr_i,
    output pad_field_t [NumPads-1:0] shadow_o,
    output logic                     commit_pending_o
);

    pad_field_t [NumPads-1:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_en, rd_en;
    logic        unused_wdata;

    assign reg_gnt_o    = reg_req_i;
    assign wr_en        = reg_req_i & reg_we_i;
    assign rd_en        = reg_req_i & ~reg_we_i;
    assign unused_wdata = ^reg_wdata_i[31:6];

    always_comb begin
        shadow_d = shadow_q;
        rdata_d  = '0;
        for (int unsigned p = 0; p < NumPads; p++) begin
            if (reg_addr_i == 6'(p)) begin
                if (wr_en) shadow_d[p] = pad_field_t'(reg_wdata_i[5:0]);
                if (rd_en) rdata_d = {26'd0, shadow_q[p]};
            end
        end
        if (rd_en && reg_addr_i == STATUS) begin
            rdata_d = {25'd0, state_i, 2'b00, pending_q, state_i == StReady};
        end
    end

    // Consumption by the sequencer wins, so a commit arriving as pending is served merges in.
    always_comb begin
        pending_d = pending_q;
        if (commit_clr_i) begin
            pending_d = 1'b0;
        end else if (wr_en && reg_addr_i == CTRL && reg_wdata_i[0]) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= {NumPads{ShadowRst}};
            pending_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            rvalid_q  <= reg_req_i;
            rdata_q   <= rdata_d;
        end
    end

    assign reg_rvalid_o     = rvalid_q;
    assign reg_rdata_o      = rdata_q;
    assign shadow_o         = shadow_q;
    assign commit_pending_o = pending_q;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Power-up and reconfiguration sequencer for the GPIO pad ring: drives every pad's tech_cfg
// bus through supplies-on, enable, configure and release, and re-applies settings on commit.
module pad_cfg_ctrl
    import pad_cfg_pkg::*;
#(
    parameter int unsigned NumPads = 36,
    parameter int unsigned SeqWait = 16,
    parameter int unsigned CfgW    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    reg_req_i,
    input  logic                    reg_we_i,
    input  logic [5:0]              reg_addr_i,
    input  logic [31:0]             reg_wdata_i,
    output logic                    reg_gnt_o,
    output logic                    reg_rvalid_o,
    output logic [31:0]             reg_rdata_o,
    output logic [NumPads*CfgW-1:0] tech_cfg_o,
    output logic [NumPads-1:0]      pad_oen_force_o,
    output logic                    pad_ready_o
);

    localparam logic [15:0] TimerLoad = 16'(SeqWait - 1);

    pad_state_t               state_q, state_d;
    logic [15:0]              timer_q, timer_d;
    logic                     started_q;
    logic [NumPads-1:0]       force_q;
    pad_field_t [NumPads-1:0] applied_q;
    pad_field_t [NumPads-1:0] shadow;
    logic                     commit_pending;
    logic                     commit_clr;
    logic                     apply_load;

    pad_cfg_regs #(
        .NumPads (NumPads)
    ) u_regs (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .reg_req_i        (reg_req_i),
        .reg_we_i         (reg_we_i),
        .reg_addr_i       (reg_addr_i),
        .reg_wdata_i      (reg_wdata_i),
        .reg_gnt_o        (reg_gnt_o),
        .reg_rvalid_o     (reg_rvalid_o),
        .reg_rdata_o      (reg_rdata_o),
        .state_i          (state_q),
        .commit_clr_i     (commit_clr),
        .shadow_o         (shadow),
        .commit_pending_o (commit_pending)
    );

    // The first edge after reset only arms the timer, so OFF lasts a full SeqWait from there.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        commit_clr = 1'b0;
        if (!started_q) begin
            timer_d = TimerLoad;
        end else begin
            unique case (state_q)
                StReady: begin
                    if (commit_pending) begin
                        state_d    = StHold;
                        timer_d    = TimerLoad;
                        commit_clr = 1'b1;
                    end
                end
                StUpd: begin
                    state_d = StRel;
                    timer_d = TimerLoad;
                end
                default: begin
                    if (timer_q == '0) begin
                        state_d = seq_next(state_q);
                        timer_d = TimerLoad;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
            endcase
        end
    end

    assign apply_load = (state_d != state_q) && (state_d == StCfg || state_d == StUpd);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StOff;
            timer_q   <= '0;
            started_q <= 1'b0;
            force_q   <= '1;
            applied_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            started_q <= 1'b1;
            force_q   <= {NumPads{state_d != StReady}};
            if (apply_load) begin
                applied_q <= shadow;
            end
        end
    end

    always_comb begin
        tech_cfg_o = '0;
        for (int unsigned p = 0; p < NumPads; p++) begin
            tech_cfg_o[p*CfgW +: CfgW] = CfgW'(pad_cfg_word(state_q, applied_q[p]));
        end
    end

    assign pad_oen_force_o = force_q;
    assign pad_ready_o     = (state_q == StReady);

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Bench for pad_cfg_ctrl: directed sequencing checks plus randomized register traffic
// compared cycle by cycle against a phase/duration reference model.
module tb_pad_cfg_ctrl;

    localparam int NP = 36;
    localparam int SW = 4;
    localparam int BW = NP * 16;

    logic          clk;
    logic          rst_ni;
    logic          reg_req;
    logic          reg_we;
    logic [5:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic          reg_gnt;
    logic          reg_rvalid;
    logic [31:0]   reg_rdata;
    logic [BW-1:0] tech_cfg;
    logic [NP-1:0] oen_force;
    logic          pad_ready;

    int n_checks = 0;
    int n_errors = 0;

    pad_cfg_ctrl #(
        .NumPads (NP),
        .SeqWait (SW),
        .CfgW    (16)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .reg_req_i       (reg_req),
        .reg_we_i        (reg_we),
        .reg_addr_i      (reg_addr),
        .reg_wdata_i     (reg_wdata),
        .reg_gnt_o       (reg_gnt),
        .reg_rvalid_o    (reg_rvalid),
        .reg_rdata_o     (reg_rdata),
        .tech_cfg_o      (tech_cfg),
        .pad_oen_force_o (oen_force),
        .pad_ready_o     (pad_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase code, cycles left in that phase, pending flag, shadow/applied.
    int         m_phase;
    int         m_left;
    bit         m_started;
    bit         m_pending;
    logic [5:0] m_shadow[NP];
    logic [5:0] m_applied[NP];
    logic       m_rvalid;
    logic [31:0] m_rdata;
    int         nxt_phase[8] = '{1, 2, 3, 4, 5, 5, 7, 4};

    task automatic check_eq(input string tag, input logic [BW-1:0] got,
                            input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase   = 0;
        m_left    = 0;
        m_started = 0;
        m_pending = 0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        for (int p = 0; p < NP; p++) begin
            m_shadow[p]  = 6'h06;
            m_applied[p] = 6'h00;
        end
    endfunction

    function automatic void enter_phase(int ph);
        m_phase = ph;
        m_left  = (ph == 7) ? 1 : SW;
        if (ph == 3 || ph == 7) begin
            for (int p = 0; p < NP; p++) m_applied[p] = m_shadow[p];
        end
    endfunction

    function automatic void model_step();
        int a;
        bit consumed;
        a = int'(reg_addr);
        m_rvalid = reg_req;
        m_rdata  = '0;
        if (reg_req && !reg_we) begin
            if (a < NP) m_rdata = {26'd0, m_shadow[a]};
            else if (a == 37) m_rdata = 32'((m_phase == 5 ? 1 : 0) + (m_pending ? 2 : 0)
                                             + m_phase * 16);
        end
        consumed = (m_phase == 5) && m_pending;
        if (!m_started) begin
            m_started = 1;
            m_left    = SW;
        end else if (m_phase == 5) begin
            if (consumed) enter_phase(6);
        end else begin
            m_left--;
            if (m_left == 0) enter_phase(nxt_phase[m_phase]);
        end
        if (consumed) m_pending = 0;
        else if (reg_req && reg_we && a == 36 && reg_wdata[0]) m_pending = 1;
        if (reg_req && reg_we && a < NP) m_shadow[a] = reg_wdata[5:0];
    endfunction

    function automatic logic [15:0] exp_word(int p);
        int w = 0;
        if (m_phase >= 1) w += 'h38;
        if (m_phase >= 2) w += 'h2;
        if (m_phase >= 3) w += int'(m_applied[p][2:0]) * 8192 + int'(m_applied[p][3]) * 256
                               + int'(m_applied[p][4]) * 128 + int'(m_applied[p][5]) * 64;
        if (m_phase == 4 || m_phase == 5) w += 1;
        return 16'(w);
    endfunction

    function automatic logic [BW-1:0] exp_bus();
        logic [BW-1:0] b = '0;
        for (int p = 0; p < NP; p++) b[p*16 +: 16] = exp_word(p);
        return b;
    endfunction

    function automatic logic [15:0] pad_word(int p);
        return tech_cfg[p*16 +: 16];
    endfunction

    task automatic compare_all();
        logic [NP-1:0] ef;
        ef = (m_phase == 5) ? '0 : '1;
        check_eq("tech_cfg", tech_cfg, exp_bus());
        check_eq("oen_force", oen_force, ef);
        check_eq("ready", pad_ready, m_phase == 5);
        check_eq("rvalid", reg_rvalid, m_rvalid);
        if (m_rvalid) check_eq("rdata", reg_rdata, m_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_ni) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic reg_op(input bit we, input int addr, input logic [31:0] data);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = 6'(addr);
        reg_wdata = data;
    endtask

    task automatic idle();
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!pad_ready && n < budget) begin
            tick();
            n++;
        end
        check_eq("ready_wait", pad_ready, 1'b1);
    endtask

    task automatic check_async_reset(input string tag);
        #1;
        check_eq({tag, "_tech"}, tech_cfg, '0);
        check_eq({tag, "_force"}, oen_force, {NP{1'b1}});
        check_eq({tag, "_ready"}, pad_ready, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_async_reset("rst");
        rst_ni = 1'b1;

        // Power-up sequence with a read/ignored-write burst and a commit during ENH.
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 4) check_eq("p0_off", pad_word(0), 16'h0000);
            if (c == 5 || c == 8) check_eq("p0_pwr", pad_word(0), 16'h0038);
            if (c == 9 || c == 12) check_eq("p0_enh", pad_word(0), 16'h003A);
            if (c == 13 || c == 16) check_eq("p0_cfg", pad_word(0), 16'hC03A);
            if (c == 17 || c == 20) check_eq("p0_rel", pad_word(0), 16'hC03B);
            if (c == 20) check_eq("ready_c20", pad_ready, 1'b0);
            if (c == 21) begin
                check_eq("ready_c21", pad_ready, 1'b1);
                check_eq("force_c21", oen_force, '0);
                check_eq("p0_ready", pad_word(0), 16'hC03B);
            end
            if (c == 3) begin
                check_eq("rd5_valid", reg_rvalid, 1'b1);
                check_eq("rd5_data", reg_rdata, 32'h6);
            end
            if (c == 4) check_eq("rd50_data", reg_rdata, 32'h0);
            if (c == 12) check_eq("status_enh", reg_rdata, 32'h22);
            idle();
            if (c == 2) reg_op(0, 5, 0);
            if (c == 3) reg_op(0, 50, 0);
            if (c == 4) reg_op(1, 50, 32'hFFFF_FFFF);
            if (c == 10) reg_op(1, 36, 1);
            if (c == 11) reg_op(0, 37, 0);
        end
        tick();
        check_eq("hold_after_ready", pad_ready, 1'b0);
        check_eq("p0_hold", pad_word(0), 16'hC03A);
        reg_op(0, 37, 0);
        tick();
        check_eq("status_hold", reg_rdata, 32'h60);
        idle();
        wait_ready(40);

        // Runtime reconfiguration of pad 12.
        reg_op(1, 12, 32'h1B);
        tick();
        reg_op(1, 36, 1);
        tick();
        idle();
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq("upd_ready_low", pad_ready, 1'b0);
            check_eq("p12_seq", pad_word(12),
                     (i < 4) ? 16'hC03A : (i == 4) ? 16'h61BA : 16'h61BB);
        end
        tick();
        check_eq("upd_ready_back", pad_ready, 1'b1);
        check_eq("p12_new", pad_word(12), 16'h61BB);
        check_eq("p11_kept", pad_word(11), 16'hC03B);

        // Shadow write landing on the UPD load edge waits for the next commit.
        reg_op(1, 36, 1);
        tick();
        idle();
        repeat (4) tick();
        reg_op(1, 3, 32'h5);
        tick();
        idle();
        wait_ready(20);
        check_eq("p3_old", pad_word(3), 16'hC03B);
        reg_op(0, 3, 0);
        tick();
        check_eq("p3_shadow", reg_rdata, 32'h5);
        reg_op(1, 36, 1);
        tick();
        idle();
        tick();
        wait_ready(20);
        check_eq("p3_new", pad_word(3), 16'hA03B);

        // Asynchronous reset in the middle of REL.
        reg_op(1, 36, 1);
        tick();
        idle();
        repeat (7) tick();
        @(posedge clk);
        model_step();
        #3;
        rst_ni = 1'b0;
        check_async_reset("arst_rel");
        model_reset();
        tick();
        rst_ni = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 4) check_eq("restart_off", pad_word(0), 16'h0000);
            if (c == 5) check_eq("restart_pwr", pad_word(0), 16'h0038);
        end
        wait_ready(40);

        // Randomized register traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            int r;
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_ni = 1'b0;
                check_async_reset("arst_rand");
                model_reset();
                idle();
                tick();
                tick();
                rst_ni = 1'b1;
            end
            r = int'($urandom_range(0, 99));
            if (r < 30) reg_op(1, int'($urandom_range(0, NP - 1)), $urandom);
            else if (r < 35) reg_op(1, 36, $urandom);
            else if (r < 50) reg_op(0, int'($urandom_range(0, 63)), $urandom);
            else if (r < 55) reg_op(1, int'($urandom_range(36, 63)), $urandom);
            else idle();
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
